// File: rtl/hcp_pkg.sv
// Shared HCP definitions: TSMP framing constants, configuration entry type
// codes, 134-bit word markers, report type codes, table depths and the
// report encapsulator state encoding.
package hcp_pkg;

  localparam logic [15:0] TSMP_ETHERTYPE      = 16'hFF01;
  localparam logic [7:0]  TSMP_SUBTYPE_REPORT = 8'h06;

  // Entry type codes, shared with the configuration frame parser.
  localparam logic [6:0] ENTRY_PORT_TYPE = 7'h00;
  localparam logic [6:0] ENTRY_HCP_REG   = 7'h01;
  localparam logic [6:0] ENTRY_FRAG      = 7'h02;
  localparam logic [6:0] ENTRY_REGROUP   = 7'h03;

  // Word position markers carried in bits [133:132].
  localparam logic [1:0] WORD_FIRST = 2'b01;
  localparam logic [1:0] WORD_MID   = 2'b11;
  localparam logic [1:0] WORD_LAST  = 2'b10;

  localparam logic [15:0] RPT_REGS_ONLY = 16'h0000;
  localparam logic [15:0] RPT_FRAG      = 16'h0001;
  localparam logic [15:0] RPT_REGROUP   = 16'h0002;

  localparam int unsigned FRAG_DEPTH    = 32;
  localparam int unsigned REGROUP_DEPTH = 256;
  localparam logic [7:0]  FRAG_LAST_IDX    = 8'(FRAG_DEPTH - 1);
  localparam logic [7:0]  REGROUP_LAST_IDX = 8'(REGROUP_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HEAD      = 3'd1,
    ST_REG0      = 3'd2,
    ST_REG1      = 3'd3,
    ST_FRAG_HI   = 3'd4,
    ST_FRAG_LO   = 3'd5,
    ST_RG_STREAM = 3'd6
  } rpt_state_e;

  typedef enum logic [1:0] {
    TBL_NONE    = 2'd0,
    TBL_FRAG    = 2'd1,
    TBL_REGROUP = 2'd2
  } rpt_table_e;

  // Unknown report types fall back to a registers-only report.
  function automatic rpt_table_e decode_report_type(input logic [15:0] t);
    case (t)
      RPT_FRAG:    return TBL_FRAG;
      RPT_REGROUP: return TBL_REGROUP;
      default:     return TBL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hcp_report_encapsulation_if.sv
// Report word stream from the encapsulator toward the transmit FIFO.
//
// Handshake: o_data_wr qualifies ov_data on every clock; there is no per-word
// ready. i_fifo_afull is sampled only in IDLE to decide whether a frame may
// start; once started, a frame is emitted on consecutive cycles regardless of
// i_fifo_afull, so the sink must have a full frame of headroom when it
// deasserts almost-full.
interface hcp_report_encapsulation_if;
  logic [133:0] ov_data;
  logic         o_data_wr;
  logic         i_fifo_afull;

  modport master (output ov_data, output o_data_wr, input i_fifo_afull);
  modport slave  (input ov_data, input o_data_wr, output i_fifo_afull);
endinterface

// File: rtl/hcp_report_timer.sv
// Periodic report timer, compiled only when HCP_PERIODIC_REPORT_EN is defined.
// Counts 0..PERIOD-1 while enabled, pulses o_tick at the terminal count and
// wraps; held at 0 while disabled.
`ifdef HCP_PERIODIC_REPORT_EN
module hcp_report_timer #(
  parameter logic [31:0] PERIOD = 32'd125_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  logic [31:0] cnt_q;

  assign o_tick = i_en && (cnt_q == PERIOD - 32'd1);

  // Period counter: cleared while disabled, wraps after the terminal count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     cnt_q <= '0;
    else if (!i_en)   cnt_q <= '0;
    else if (o_tick)  cnt_q <= '0;
    else              cnt_q <= cnt_q + 32'd1;
  end

endmodule
`endif

// File: rtl/hcp_report_encapsulation.sv
// TSMP report frame builder. Emits HEAD, two register words and optionally
// the fragmentation or regroup mapping table, one 134-bit word per cycle.
// Optional feature macro: HCP_PERIODIC_REPORT_EN adds a periodic report timer.
module hcp_report_encapsulation
  import hcp_pkg::*;
`ifdef HCP_PERIODIC_REPORT_EN
#(
  parameter logic [31:0] REPORT_PERIOD = 32'd125_000_000
)
`endif
(
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [47:0]                  iv_dmac,
  input  logic [47:0]                  iv_smac,
  input  logic [15:0]                  iv_report_type,
  input  logic [7:0]                   iv_chip_port_type,
  input  logic [1:0]                   iv_hcp_state,
  input  logic                         i_report_req,
  output logic [4:0]                   ov_frag_ram_raddr,
  output logic                         o_frag_ram_rd,
  input  logic [151:0]                 iv_frag_ram_rdata,
  output logic [7:0]                   ov_regroup_ram_raddr,
  output logic                         o_regroup_ram_rd,
  input  logic [70:0]                  iv_regroup_ram_rdata,
  hcp_report_encapsulation_if.master   rpt,
  output rpt_state_e                   o_state_dbg
);

  rpt_state_e   state_q, state_d;
  logic         pending_q;
  logic         timer_tick;
  logic         start;
  logic [47:0]  smac_q, dmac_q;
  logic [7:0]   port_type_q;
  logic [1:0]   hcp_state_q;
  logic [15:0]  report_type_q;
  rpt_table_e   table_q;
  logic [7:0]   entry_q;
  logic [127:0] frag_lo_q;
  logic [133:0] word_c;
  logic         wr_c;
  logic [1:0]   marker_c;

`ifdef HCP_PERIODIC_REPORT_EN
  hcp_report_timer #(.PERIOD(REPORT_PERIOD)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (iv_hcp_state != 2'd0),
    .o_tick  (timer_tick)
  );
`else
  assign timer_tick = 1'b0;
`endif

  assign start       = (state_q == ST_IDLE) && pending_q && !rpt.i_fifo_afull;
  assign o_state_dbg = state_q;
  assign rpt.ov_data   = word_c;
  assign rpt.o_data_wr = wr_c;

  // Pending report flag; a new request wins over the clear at frame start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        pending_q <= 1'b0;
    else if (i_report_req || timer_tick) pending_q <= 1'b1;
    else if (start)                      pending_q <= 1'b0;
  end

  // Frame snapshot, taken once at start and held for the whole frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      smac_q        <= '0;
      dmac_q        <= '0;
      port_type_q   <= '0;
      hcp_state_q   <= '0;
      report_type_q <= '0;
      table_q       <= TBL_NONE;
    end else if (start) begin
      smac_q        <= iv_smac;
      dmac_q        <= iv_dmac;
      port_type_q   <= iv_chip_port_type;
      hcp_state_q   <= iv_hcp_state;
      report_type_q <= iv_report_type;
      table_q       <= decode_report_type(iv_report_type);
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Table entry index: cleared on entry to a table and on return to IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      entry_q <= '0;
    else if (state_d == ST_IDLE || state_q == ST_REG1)
      entry_q <= '0;
    else if (state_q == ST_FRAG_LO || state_q == ST_RG_STREAM)
      entry_q <= entry_q + 8'd1;
  end

  // Low 128 bits of the frag entry, replayed as the FRAG_LO word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                   frag_lo_q <= '0;
    else if (state_q == ST_FRAG_HI) frag_lo_q <= iv_frag_ram_rdata[127:0];
  end

  // Next state, output word and table read strobes.
  always_comb begin
    state_d              = state_q;
    word_c               = '0;
    wr_c                 = 1'b0;
    marker_c             = WORD_MID;
    o_frag_ram_rd        = 1'b0;
    ov_frag_ram_raddr    = '0;
    o_regroup_ram_rd     = 1'b0;
    ov_regroup_ram_raddr = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_HEAD;
      end
      ST_HEAD: begin
        wr_c    = 1'b1;
        word_c  = {WORD_FIRST, 4'h0, smac_q, dmac_q,
                   TSMP_ETHERTYPE, TSMP_SUBTYPE_REPORT, 8'h00};
        state_d = ST_REG0;
      end
      ST_REG0: begin
        wr_c    = 1'b1;
        word_c  = {WORD_MID, 4'h0,
                   1'b1, ENTRY_PORT_TYPE, 24'h0, 24'h0, port_type_q,
                   1'b1, ENTRY_HCP_REG, 24'h0, 30'h0, hcp_state_q};
        state_d = ST_REG1;
      end
      ST_REG1: begin
        wr_c = 1'b1;
        case (table_q)
          TBL_FRAG: begin
            o_frag_ram_rd = 1'b1;
            state_d       = ST_FRAG_HI;
          end
          TBL_REGROUP: begin
            o_regroup_ram_rd = 1'b1;
            state_d          = ST_RG_STREAM;
          end
          default: begin
            marker_c = WORD_LAST;
            state_d  = ST_IDLE;
          end
        endcase
        word_c = {marker_c, 4'h0,
                  1'b1, ENTRY_HCP_REG, 24'h1, 16'h0, report_type_q, 64'h0};
      end
      ST_FRAG_HI: begin
        wr_c    = 1'b1;
        word_c  = {WORD_MID, 4'h0, 1'b1, ENTRY_FRAG, 24'(entry_q),
                   72'h0, iv_frag_ram_rdata[151:128]};
        state_d = ST_FRAG_LO;
      end
      ST_FRAG_LO: begin
        wr_c = 1'b1;
        if (entry_q == FRAG_LAST_IDX) begin
          marker_c = WORD_LAST;
          state_d  = ST_IDLE;
        end else begin
          o_frag_ram_rd     = 1'b1;
          ov_frag_ram_raddr = entry_q[4:0] + 5'd1;
          state_d           = ST_FRAG_HI;
        end
        word_c = {marker_c, 4'h0, frag_lo_q};
      end
      ST_RG_STREAM: begin
        wr_c = 1'b1;
        if (entry_q == REGROUP_LAST_IDX) begin
          marker_c = WORD_LAST;
          state_d  = ST_IDLE;
        end else begin
          o_regroup_ram_rd     = 1'b1;
          ov_regroup_ram_raddr = entry_q + 8'd1;
        end
        word_c = {marker_c, 4'h0, 1'b1, ENTRY_REGROUP, 24'(entry_q), 18'h0,
                  iv_regroup_ram_rdata[70:57], iv_regroup_ram_rdata[56:9],
                  7'h0, iv_regroup_ram_rdata[8:0]};
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hcp_report_encapsulation.sv
// Directed bench for hcp_report_encapsulation: table-driven report types plus
// hand-written sequences for backpressure, coalescing and mid-frame reset.
`timescale 1ns/1ps
module tb_hcp_report_encapsulation;
  import hcp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [47:0]  dmac, smac;
  logic [15:0]  rtype;
  logic [7:0]   port_type;
  logic [1:0]   hcp_state;
  logic         req;
  logic [4:0]   frag_addr;
  logic         frag_rd;
  logic [151:0] frag_rdata = '0;
  logic [7:0]   rg_addr;
  logic         rg_rd;
  logic [70:0]  rg_rdata = '0;
  rpt_state_e   state_dbg;

  hcp_report_encapsulation_if rpt_if ();

  hcp_report_encapsulation dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .iv_dmac              (dmac),
    .iv_smac              (smac),
    .iv_report_type       (rtype),
    .iv_chip_port_type    (port_type),
    .iv_hcp_state         (hcp_state),
    .i_report_req         (req),
    .ov_frag_ram_raddr    (frag_addr),
    .o_frag_ram_rd        (frag_rd),
    .iv_frag_ram_rdata    (frag_rdata),
    .ov_regroup_ram_raddr (rg_addr),
    .o_regroup_ram_rd     (rg_rd),
    .iv_regroup_ram_rdata (rg_rdata),
    .rpt                  (rpt_if),
    .o_state_dbg          (state_dbg)
  );

  // ---------------- table models ----------------
  logic [151:0] frag_mem [32];
  logic [70:0]  rg_mem   [256];
  int frag_reads = 0;
  int rg_reads   = 0;
  int dual_reads = 0;

  always @(posedge clk) begin
    if (frag_rd) begin
      frag_rdata <= frag_mem[frag_addr];
      frag_reads <= frag_reads + 1;
    end
    if (rg_rd) begin
      rg_rdata <= rg_mem[rg_addr];
      rg_reads <= rg_reads + 1;
    end
    if (frag_rd && rg_rd) dual_reads <= dual_reads + 1;
  end

  // ---------------- scoreboard ----------------
  logic [133:0] exp_q[$];
  logic [133:0] got_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [133:0] got, input logic [133:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic void build_expected(input logic [15:0] t, input logic [7:0] pt,
                                         input logic [1:0] st, input logic [47:0] sm,
                                         input logic [47:0] dm);
    logic [133:0] w;
    exp_q.delete();
    w = '0; w[133:132] = 2'b01; w[127:80] = sm; w[79:32] = dm;
    w[31:16] = 16'hFF01; w[15:8] = 8'h06;
    exp_q.push_back(w);
    w = '0; w[133:132] = 2'b11; w[127] = 1'b1; w[71:64] = pt;
    w[63] = 1'b1; w[62:56] = 7'h01; w[1:0] = st;
    exp_q.push_back(w);
    w = '0; w[133:132] = (t == 16'h1 || t == 16'h2) ? 2'b11 : 2'b10;
    w[127] = 1'b1; w[126:120] = 7'h01; w[119:96] = 24'd1; w[79:64] = t;
    exp_q.push_back(w);
    if (t == 16'h1) begin
      for (int n = 0; n < 32; n++) begin
        w = '0; w[133:132] = 2'b11; w[127] = 1'b1; w[126:120] = 7'h02;
        w[119:96] = 24'(n); w[23:0] = frag_mem[n][151:128];
        exp_q.push_back(w);
        w = '0; w[133:132] = (n == 31) ? 2'b10 : 2'b11; w[127:0] = frag_mem[n][127:0];
        exp_q.push_back(w);
      end
    end else if (t == 16'h2) begin
      for (int n = 0; n < 256; n++) begin
        w = '0; w[133:132] = (n == 255) ? 2'b10 : 2'b11; w[127] = 1'b1;
        w[126:120] = 7'h03; w[119:96] = 24'(n);
        w[77:64] = rg_mem[n][70:57]; w[63:16] = rg_mem[n][56:9]; w[8:0] = rg_mem[n][8:0];
        exp_q.push_back(w);
      end
    end
  endfunction

  // ---------------- driver / monitor tasks ----------------
  task automatic pulse_req();
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  // Waits (bounded) for the first word, then gathers words until the last marker.
  task automatic collect(output bit ok, output int waited);
    int w;
    bit seen;
    bit gap;
    logic [133:0] last_w;
    got_q.delete();
    ok = 1'b0; w = 0; seen = 1'b0; gap = 1'b0; last_w = '0;
    while (!seen && w < 400) begin
      @(negedge clk); w++;
      seen = rpt_if.o_data_wr;
    end
    waited = w;
    if (seen) begin
      last_w = rpt_if.ov_data;
      got_q.push_back(last_w);
      while (last_w[133:132] != 2'b10 && got_q.size() < 300 && !gap) begin
        @(negedge clk);
        if (rpt_if.o_data_wr) begin
          last_w = rpt_if.ov_data;
          got_q.push_back(last_w);
        end else gap = 1'b1;
      end
      ok = !gap && (last_w[133:132] == 2'b10);
    end
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, 134'(got_q.size()), 134'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), (i < got_q.size()) ? got_q[i] : 134'bx, exp_q[i]);
  endtask

  task automatic count_idle_words(input int cycles, output int words);
    words = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (rpt_if.o_data_wr) words++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  rpt_if.ov_data, '0);
    check({tag, "_wr"},    134'(rpt_if.o_data_wr), 0);
    check({tag, "_frd"},   134'(frag_rd), 0);
    check({tag, "_faddr"}, 134'(frag_addr), 0);
    check({tag, "_rrd"},   134'(rg_rd), 0);
    check({tag, "_raddr"}, 134'(rg_addr), 0);
    check({tag, "_state"}, 134'(state_dbg), 134'(ST_IDLE));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] rtype;
    logic [7:0]  port;
    logic [1:0]  st;
    logic [47:0] smac;
    logic [47:0] dmac;
    int          exp_len;
    int          exp_frag_rd;
    int          exp_rg_rd;
  } vec_t;

  vec_t vecs [4];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit ok, ok2;
    int waited, words, f0, r0, seen_words;
    logic [15:0] sv_t; logic [7:0] sv_p; logic [1:0] sv_s; logic [47:0] sv_sm, sv_dm;

    vecs[0] = '{16'h0000, 8'h0F, 2'd2, 48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F, 3, 0, 0};
    vecs[1] = '{16'h0001, 8'h33, 2'd1, 48'hC0FF_EE00_0001, 48'h0200_0000_00AA, 67, 32, 0};
    vecs[2] = '{16'h0002, 8'hA5, 2'd3, 48'h1234_5678_9ABC, 48'hFEDC_BA98_7654, 259, 0, 256};
    vecs[3] = '{16'h0007, 8'hFF, 2'd0, 48'hAAAA_5555_AAAA, 48'h5555_AAAA_5555, 3, 0, 0};

    for (int n = 0; n < 32; n++)
      frag_mem[n] = {24'h100000 + 24'(n), {4{32'hC0DE_0000 + 32'(n)}}};
    frag_mem[5] = {24'hABCDEF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    for (int n = 0; n < 256; n++)
      rg_mem[n] = {14'(n) ^ 14'h2AA, 48'(n) * 48'h0001_0001_0001, 9'(n) ^ 9'h155};

    dmac = '0; smac = '0; rtype = '0; port_type = '0; hcp_state = '0; req = 1'b0;
    rpt_if.i_fifo_afull = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    count_idle_words(5, words);
    check("reset_no_pending", 134'(words), 0);

    // Table-driven report types.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rtype = vecs[i].rtype; port_type = vecs[i].port; hcp_state = vecs[i].st;
      smac = vecs[i].smac; dmac = vecs[i].dmac;
      f0 = frag_reads; r0 = rg_reads;
      pulse_req();
      collect(ok, waited);
      check($sformatf("v%0d_complete", i), 134'(ok), 1);
      check($sformatf("v%0d_latency", i), 134'(waited), 2);
      check($sformatf("v%0d_len", i), 134'(got_q.size()), 134'(vecs[i].exp_len));
      build_expected(vecs[i].rtype, vecs[i].port, vecs[i].st, vecs[i].smac, vecs[i].dmac);
      compare_frame($sformatf("v%0d", i));
      @(negedge clk);
      check($sformatf("v%0d_frag_reads", i), 134'(frag_reads - f0), 134'(vecs[i].exp_frag_rd));
      check($sformatf("v%0d_rg_reads", i), 134'(rg_reads - r0), 134'(vecs[i].exp_rg_rd));
      if (i == 0 && got_q.size() >= 3) begin
        check("regs_markers", {got_q[0][133:132], got_q[1][133:132], got_q[2][133:132]}, 6'b01_11_10);
        check("regs_port_type", got_q[1][71:64], 8'h0F);
        check("regs_hcp_state", got_q[1][1:0], 2'd2);
        check("regs_rtype", got_q[2][79:64], 16'h0);
      end
      if (i == 1 && got_q.size() >= 15) begin
        check("frag_e5_addr", got_q[13][119:96], 24'd5);
        check("frag_e5_hi", got_q[13][23:0], 24'hABCDEF);
        check("frag_e5_lo", got_q[14][127:0], 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      end
      if (i == 2 && got_q.size() >= 259) begin
        check("rg_last_marker", got_q[258][133:132], 2'b10);
        check("rg_last_lsb", got_q[258][8:0], rg_mem[255][8:0]);
      end
    end
    check("no_dual_reads", 134'(dual_reads), 0);

    // Backpressure at frame start; afull and input changes mid-frame are ignored.
    @(posedge clk); #1;
    rtype = 16'h1; port_type = 8'h5A; hcp_state = 2'd1;
    smac = 48'h0101_0202_0303; dmac = 48'h0404_0505_0606;
    rpt_if.i_fifo_afull = 1'b1;
    pulse_req();
    count_idle_words(10, words);
    check("bp_blocked", 134'(words), 0);
    @(posedge clk); #1 rpt_if.i_fifo_afull = 1'b0;
    @(negedge clk);
    check("bp_start_cycle_wr", 134'(rpt_if.o_data_wr), 0);
    @(negedge clk);
    check("bp_head_wr", 134'(rpt_if.o_data_wr), 1);
    check("bp_head_marker", rpt_if.ov_data[133:132], 2'b01);
    build_expected(rtype, port_type, hcp_state, smac, dmac);
    void'(exp_q.pop_front());
    sv_t = rtype; sv_p = port_type; sv_s = hcp_state; sv_sm = smac; sv_dm = dmac;
    rpt_if.i_fifo_afull = 1'b1;
    port_type = 8'h77; hcp_state = 2'd0; rtype = 16'h2; smac = 48'hDEAD_BEEF_0000;
    collect(ok, waited);
    check("bp_complete", 134'(ok), 1);
    check("bp_no_stall", 134'(waited), 1);
    compare_frame("bp");
    rpt_if.i_fifo_afull = 1'b0;
    rtype = sv_t; port_type = sv_p; hcp_state = sv_s; smac = sv_sm; dmac = sv_dm;

    // Three requests during a frag frame coalesce into one following frame.
    pulse_req();
    fork
      collect(ok, waited);
      begin
        repeat (10) @(posedge clk);
        pulse_req(); pulse_req(); pulse_req();
      end
    join
    check("coal_a_complete", 134'(ok), 1);
    check("coal_a_len", 134'(got_q.size()), 67);
    collect(ok2, waited);
    check("coal_b_complete", 134'(ok2), 1);
    check("coal_b_gap", 134'(waited), 2);
    build_expected(rtype, port_type, hcp_state, smac, dmac);
    compare_frame("coal_b");
    count_idle_words(150, words);
    check("coal_no_third", 134'(words), 0);

    // Request held into the start cycle yields exactly one extra frame.
    rtype = 16'h0;
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    collect(ok, waited);
    check("sc_first_complete", 134'(ok), 1);
    collect(ok2, waited);
    check("sc_second_complete", 134'(ok2), 1);
    check("sc_second_gap", 134'(waited), 2);
    check("sc_second_len", 134'(got_q.size()), 3);
    count_idle_words(30, words);
    check("sc_no_third", 134'(words), 0);

    // Reset at word 30 of a frag frame, then a clean frame afterwards.
    rtype = 16'h1;
    pulse_req();
    seen_words = 0; waited = 0;
    while (seen_words < 30 && waited < 400) begin
      @(negedge clk); waited++;
      if (rpt_if.o_data_wr) seen_words++;
    end
    check("rstmid_reached", 134'(seen_words), 30);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("rstmid_async");
    @(posedge clk); #1 check_outputs_zero("rstmid_edge");
    @(negedge clk) rst_n = 1'b1;
    count_idle_words(20, words);
    check("rstmid_no_resume", 134'(words), 0);
    pulse_req();
    collect(ok, waited);
    check("rstmid_new_complete", 134'(ok), 1);
    build_expected(rtype, port_type, hcp_state, smac, dmac);
    compare_frame("rstmid_new");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hcp_report_encapsulation.md
# hcp_report_encapsulation

Transmit-side counterpart of the HCP's controller-interactive configuration decapsulator. It builds TSMP report frames toward the controller, one 134-bit word per cycle. Each frame carries the current HCP register values (chip port type, HCP state, report type) and, depending on the report type, either the fragmentation mapping table or the regroup mapping table, read back through the tables' read ports. Entry encoding is identical to the configuration frames, so the controller can parse a report with its configuration parser.

## Interface
- REPORT_PERIOD, 32'd125_000_000, clock cycles between periodic reports (used only with the macro).
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- iv_dmac  in  48  DMAC of the last received TSMP frame (HCP MAC); becomes report SMAC
- iv_smac  in  48  SMAC of the last received TSMP frame (controller MAC); becomes report DMAC
- iv_report_type  in  16  0x0000 registers only, 0x0001 plus frag table, 0x0002 plus regroup table, others treated as 0x0000
- iv_chip_port_type  in  8  current chip port type
- iv_hcp_state  in  2  current HCP state
- i_report_req  in  1  single-cycle report request (driven by the inbound-packet pulse)
- i_fifo_afull  in  1  downstream almost-full; blocks frame start only
- ov_frag_ram_raddr  out  5  frag table read address
- o_frag_ram_rd  out  1  frag table read strobe
- iv_frag_ram_rdata  in  152  frag read data, valid 1 cycle after the strobe
- ov_regroup_ram_raddr  out  8  regroup table read address
- o_regroup_ram_rd  out  1  regroup table read strobe
- iv_regroup_ram_rdata  in  71  regroup read data, valid 1 cycle after the strobe
- ov_data  out  134  frame word: [133:132] 01 first / 11 middle / 10 last; [131:128] = 0
- o_data_wr  out  1  word valid

## Operation
- Pending flag: set by i_report_req or by a timer expiry.
  - Set has priority over the same-cycle clear caused by a frame start.
  - Multiple requests coalesce into one pending report.
- Frame start: in IDLE with pending=1 and i_fifo_afull=0. Start clears pending and snapshots MACs, registers and report type. The snapshot is used for the whole frame.
- States: IDLE → HEAD → REG0 → REG1 → (IDLE | FRAG_HI ↔ FRAG_LO | RG_STREAM) → IDLE.
- HEAD word:
  - [127:80] snapshot iv_smac; [79:32] snapshot iv_dmac.
  - [31:16] 16'hFF01; [15:8] 8'h06; [7:0] 0.
- REG0 word:
  - [127:64] = {1, 7'h00, 24'h0, 24'h0, chip_port_type}.
  - [63:0] = {1, 7'h01, 24'h0, 30'h0, hcp_state}.
- REG1 word:
  - [127:64] = {1, 7'h01, 24'h1, 16'h0, report_type}; [63:0] = 0.
  - Marked 10 (last) for a registers-only frame.
  - Otherwise marked 11, and the state issues read address 0 of the selected table.
- FRAG_HI word for entry n:
  - [127:96] = {1, 7'h02, 24'(n)}; [23:0] = rdata[151:128]; other bits 0.
  - Captures rdata[127:0] in an internal register.
- FRAG_LO word: [127:0] = captured rdata[127:0]. Also issues the read of entry n+1 when n<31. Entry 31's LO word is marked 10.
- RG_STREAM word for entry n:
  - {1, 7'h03, 24'(n)} in [127:96]; [95:78] = 0.
  - [77:64] = rdata[70:57]; [63:16] = rdata[56:9]; [15:9] = 0; [8:0] = rdata[8:0].
  - Issues the read of entry n+1 when n<255. Entry 255 is marked 10.
- Address counters wrap only by returning to IDLE. No table is read outside its own state path.

## Timing
- Start condition at cycle t → HEAD word with o_data_wr=1 at t+1.
- o_data_wr stays high with no gaps until the last word.
- Frame lengths: 3 words (registers only); 67 words (frag, 3+64); 259 words (regroup, 3+256).
- i_fifo_afull is ignored mid-frame. The downstream must reserve 259 words of headroom when it deasserts almost-full.
- Minimum gap between frames: 1 IDLE cycle.
- Reset values: ov_data=0, o_data_wr=0, strobes=0, addresses=0, pending=0, timer=0, state IDLE.
- Reset mid-frame aborts the frame immediately; no last word is emitted.

## Configuration
- HCP_PERIODIC_REPORT_EN defined:
  - Timer counts 0..REPORT_PERIOD-1 while iv_hcp_state≠0 and sets pending at the terminal count, then wraps to 0.
  - Timer is held at 0 while iv_hcp_state=0.
- Undefined: no timer logic; reports come from i_report_req only.

## Structure
- Shared package hcp_pkg holds:
  - TSMP ethertype 16'hFF01 and report subtype 8'h06.
  - Entry type codes 7'h00..7'h03.
  - Word markers 01/11/10.
  - Report type codes and table depths (32, 256).
- Sub-module hcp_report_timer (period counter, compiled only under the macro).

## Test plan
- Registers only: report_type=0, port_type=8'h0F, state=2, req pulse → 3 words.
  - Marker sequence 01, 11, 10.
  - REG0[71:64]=8'h0F and [1:0]=2; REG1[79:64]=0.
- Frag report: report_type=1, entry 5 = 152'hABCDEF followed by 128 bits of pattern → 67 contiguous words.
  - Word 13 carries addr field 5 and [23:0]=24'hABCDEF.
  - Word 14 carries the pattern.
  - Last word marked 10.
- Regroup report: report_type=2 → 259 words, one read per cycle. Entry 255 is the last word, with [8:0] equal to rdata[8:0].
- Backpressure: i_fifo_afull=1 with req → no output until afull drops, then HEAD follows 1 cycle later. Asserting afull mid-frame does not stall the frame.
- Coalescing: 3 req pulses during a frag frame → exactly one following frame. A req in the start cycle yields one additional frame.
- Reset at word 30 of a frag frame → all outputs 0 next edge. After reset a new req produces a full, correct frame.
